// File: rtl/cpu_mem_bridge.sv
// rtl/cpu_mem_bridge.sv - splits core memory requests into 16-bit halfword beats
// and stalls the core until the assembled result is ready.
module cpu_mem_bridge #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_rd,
  input  logic              cpu_req_wr,
  input  logic [1:0]        cpu_req_sz,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [47:0]       cpu_data_in,
  output logic              cpu_enable,
  output logic              cpu_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_be,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        sz_q;
  logic [1:0]        beat_idx;
  logic [1:0]        last_idx;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic              err_q;
  logic [7:0]        tmo_cnt;

  logic req;
  logic fault;
  logic tmo_hit;
  logic last_beat;

  assign req       = cpu_req_rd | cpu_req_wr;
  // A read wins over a simultaneous write, so only a pure write can fault on sz=3
  assign fault     = (cpu_req_wr && !cpu_req_rd && cpu_req_sz == 2'd3) ||
                     (cpu_req_sz != 2'd0 && cpu_addr[0]);
  assign tmo_hit   = !mem_ack && (tmo_cnt == 8'(TIMEOUT - 1));
  assign last_beat = mem_ack && (beat_idx == last_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = fault ? DONE : BEAT;
      BEAT:    if (last_beat || tmo_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_be     = 2'b00;
    mem_addr   = '0;
    mem_wdata  = 16'h0000;
    cpu_enable = (state == DONE) || (state == IDLE && !req);
    cpu_err    = (state == DONE) && err_q;
    if (state == BEAT) begin
      mem_req = 1'b1;
      mem_we  = we_q;
      if (sz_q == 2'd0) begin
        mem_addr  = {addr_q[ADDR_W-1:1], 1'b0};
        mem_be    = addr_q[0] ? 2'b10 : 2'b01;
        mem_wdata = {wdata_q[7:0], wdata_q[7:0]};
      end else begin
        mem_addr  = addr_q + ADDR_W'({beat_idx, 1'b0});
        mem_be    = 2'b11;
        mem_wdata = beat_idx[0] ? wdata_q[31:16] : wdata_q[15:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      sz_q        <= 2'd0;
      wdata_q     <= 32'h0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      beat_idx    <= 2'd0;
      last_idx    <= 2'd0;
      tmo_cnt     <= 8'd0;
      cpu_data_in <= 48'h0;
    end else begin
      case (state)
        IDLE: if (req) begin
          if (fault) begin
            err_q <= 1'b1;
          end else begin
            addr_q      <= cpu_addr;
            sz_q        <= cpu_req_sz;
            wdata_q     <= cpu_wdata;
            we_q        <= !cpu_req_rd;
            last_idx    <= (cpu_req_sz == 2'd3) ? 2'd2 : (cpu_req_sz == 2'd2) ? 2'd1 : 2'd0;
            beat_idx    <= 2'd0;
            tmo_cnt     <= 8'd0;
            cpu_data_in <= 48'h0;
            err_q       <= cpu_req_rd & cpu_req_wr;
          end
        end
        BEAT: if (mem_ack) begin
          tmo_cnt  <= 8'd0;
          beat_idx <= beat_idx + 2'd1;
          if (!we_q) begin
            if (sz_q == 2'd0) begin
              cpu_data_in <= {40'd0, (addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0])};
            end else begin
              case (beat_idx)
                2'd0:    cpu_data_in[15:0]  <= mem_rdata;
                2'd1:    cpu_data_in[31:16] <= mem_rdata;
                default: cpu_data_in[47:32] <= mem_rdata;
              endcase
            end
          end
        end else begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (tmo_hit) err_q <= 1'b1;
        end
        DONE:    err_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cpu_mem_bridge.md
Name: cpu_mem_bridge

Overview:
- Sits directly upstream of the Cpu core.
- Services the core's registered memory request (read/write, size, address, write data) over a narrower 16-bit memory bus, splitting each request into halfword beats.
- Returns the assembled read data on the core's data input bus (48 bits, wide enough for the longest instruction).
- Drives the core's enable input low to stall it for the whole transaction.

Parameters:
- ADDR_W, 32, byte-address width on both CPU and memory sides.
- TIMEOUT, 255, maximum cycles to wait for mem_ack on one beat before aborting (1..255).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req_rd  in  1  core requests a read (level, held until the core's next enabled edge).
- cpu_req_wr  in  1  core requests a write (level, same rule).
- cpu_req_sz  in  2  0=8-bit, 1=16-bit, 2=32-bit, 3=48-bit (read only).
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  32  write data, little-endian.
- cpu_data_in  out  48  read data to the core (its data_in).
- cpu_enable  out  1  core enable; low = core stalled.
- cpu_err  out  1  one-cycle pulse on a faulted request.
- mem_req  out  1  beat request.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_W  halfword-aligned beat address (bit 0 always 0).
- mem_be  out  2  byte enables: [0]=low byte, [1]=high byte.
- mem_wdata  out  16  beat write data.
- mem_ack  in  1  memory accepts/completes the beat in this cycle.
- mem_rdata  in  16  read data; valid when mem_ack is high on a read beat.

Behaviour:
- Reset (async, immediate): state IDLE; mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, cpu_data_in=0, cpu_err=0, beat and timeout counters=0. Any in-flight beat is dropped, with no completion.
- Requests reaching this block are always registered outputs of the core.
- cpu_enable is combinational: high in DONE, or in IDLE with cpu_req_rd=cpu_req_wr=0; otherwise low. The core therefore stalls on the first edge where its request is visible.
- States:
  - IDLE:
    - On a request, latch addr/size/data/direction; beats = 1,1,2,3 for sz 0..3. Go to BEAT.
    - Faults latch nothing and go straight to DONE with cpu_err=1 for one cycle and no memory access:
      - sz=3 with cpu_req_wr;
      - sz≥1 with addr[0]=1.
    - If rd and wr are both high, perform the read, ignore the write, and pulse cpu_err.
  - BEAT:
    - mem_req=1, with mem_addr/mem_we/mem_be/mem_wdata held stable until mem_ack.
    - On mem_ack: store the beat and advance; after the last beat go to DONE. Back-to-back beats have no idle cycle between them.
    - The timeout counter increments each cycle without an ack and is cleared on ack. When it reaches TIMEOUT: abort, drop mem_req, go to DONE, pulse cpu_err. cpu_data_in then holds the beats received so far, with the rest zero.
  - DONE:
    - One cycle; cpu_enable=1 and cpu_data_in is valid.
    - Go to IDLE unconditionally. The still-asserted request is not restarted, because the core updates its request on this same edge.
- Beat k of a multi-halfword access:
  - Address: mem_addr = addr + 2k.
  - Read: cpu_data_in[16k+15:16k] = mem_rdata.
  - Write: mem_wdata = cpu_wdata[16k+15:16k], mem_be=2'b11.
- Byte read: result = addr[0] ? mem_rdata[15:8] : mem_rdata[7:0], zero-extended to 48 bits.
- Byte write: mem_be = addr[0] ? 2'b10 : 2'b01; mem_wdata = {cpu_wdata[7:0], cpu_wdata[7:0]}; mem_addr = {addr[ADDR_W-1:1], 1'b0}.
- Reads smaller than 48 bits zero-fill the unused upper bits. cpu_data_in is cleared on entry to BEAT and holds its value from DONE until the next request.
- Address increments wrap modulo 2^ADDR_W.
- Latency with zero-wait memory: beats+1 stalled cycles; data is visible at the core on the DONE edge.

Test Plan:
- 32-bit read at 0x100, mem_ack every cycle, rdata 0x5678 then 0x1234 → beats at mem_addr 0x100 and 0x102 on consecutive cycles; cpu_enable low 3 cycles; in DONE cpu_data_in=0x000012345678.
- 48-bit read at 0xFFFFFFFC, rdata 0xAAAA/0xBBBB/0xCCCC → addresses 0xFFFFFFFC, 0xFFFFFFFE, 0x00000000 (wrap); cpu_data_in=0xCCCCBBBBAAAA.
- Byte write 0x5A to 0x201 with ack delayed 4 cycles → mem_be=10, mem_wdata=0x5A5A, mem_addr=0x200 held stable for 5 cycles; DONE one cycle later; cpu_err=0.
- Misaligned 16-bit read at 0x3 → no mem_req; next cycle DONE with cpu_err=1 and cpu_enable=1. Write with sz=3 → same response.
- TIMEOUT=8, 32-bit read, first beat acked with 0x1111, second never acked → mem_req drops after 8 unacked cycles; cpu_err pulses; cpu_data_in=0x000000001111.
- Async rst asserted mid-beat (between edges) → mem_req=0 immediately; after release, state is IDLE and a fresh 16-bit read completes normally.
